// File: rtl/tcdm_bank_scheduler.sv
// tcdm_bank_scheduler: round-robin sharing of one single-port TCDM bank
// between NumIn requesters. Read data comes back through a small response
// FIFO guarded by credits, so a stalled consumer never loses a response.
module tcdm_bank_scheduler #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MetaWidth = 8,
  parameter int unsigned RespDepth = 2,
  localparam int unsigned BeWidth  = DataWidth / 8,
  localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumIn-1:0]             req_valid_i,
  output logic [NumIn-1:0]             req_ready_o,
  input  logic [NumIn-1:0]             req_wen_i,
  input  logic [NumIn*AddrWidth-1:0]   req_addr_i,
  input  logic [NumIn*BeWidth-1:0]     req_be_i,
  input  logic [NumIn*DataWidth-1:0]   req_wdata_i,
  input  logic [NumIn*MetaWidth-1:0]   req_meta_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [IdxWidth-1:0]          resp_idx_o,
  output logic [DataWidth-1:0]         resp_rdata_o,
  output logic [MetaWidth-1:0]         resp_meta_o,
  output logic                         bank_req_o,
  output logic                         bank_we_o,
  output logic [AddrWidth-1:0]         bank_addr_o,
  output logic [BeWidth-1:0]           bank_be_o,
  output logic [DataWidth-1:0]         bank_wdata_o,
  input  logic [DataWidth-1:0]         bank_rdata_i
);

  localparam int unsigned OccWidth = $clog2(RespDepth + 1);
  localparam int unsigned PtrWidth = $clog2(RespDepth);

  // Per-requester views of the packed request fields
  logic [AddrWidth-1:0] addr_arr  [NumIn];
  logic [BeWidth-1:0]   be_arr    [NumIn];
  logic [DataWidth-1:0] wdata_arr [NumIn];
  logic [MetaWidth-1:0] meta_arr  [NumIn];
  logic [NumIn-1:0]     eligible;

  // State
  logic [IdxWidth-1:0]  rr_q, rr_d;
  logic                 inflight_q, inflight_d;
  logic [IdxWidth-1:0]  inflight_idx_q;
  logic [MetaWidth-1:0] inflight_meta_q;
  logic [OccWidth-1:0]  cnt_q, cnt_d;
  logic [PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DataWidth-1:0] fifo_data_q [RespDepth];
  logic [IdxWidth-1:0]  fifo_idx_q  [RespDepth];
  logic [MetaWidth-1:0] fifo_meta_q [RespDepth];

  // Control
  logic                 grant_valid, grant, grant_read;
  logic [IdxWidth-1:0]  grant_idx;
  logic                 fifo_empty, pop, fifo_pop, fifo_push, read_credit;
  logic [OccWidth:0]    occ_q, occ_limit;
  int unsigned          cand;

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_unpack
    assign addr_arr[gi]    = req_addr_i[gi*AddrWidth +: AddrWidth];
    assign be_arr[gi]      = req_be_i[gi*BeWidth +: BeWidth];
    assign wdata_arr[gi]   = req_wdata_i[gi*DataWidth +: DataWidth];
    assign meta_arr[gi]    = req_meta_i[gi*MetaWidth +: MetaWidth];
    // Writes never need a credit; reads need a free response slot
    assign eligible[gi]    = req_valid_i[gi] & (req_wen_i[gi] | read_credit);
    assign req_ready_o[gi] = grant & (grant_idx == IdxWidth'(gi));
  end

  // Credit: a slot freed by this cycle's pop may be reused by this cycle's read
  assign occ_q       = (OccWidth+1)'(cnt_q) + (OccWidth+1)'(inflight_q);
  assign occ_limit   = (OccWidth+1)'(RespDepth) + (OccWidth+1)'(pop);
  assign read_credit = occ_q < occ_limit;

  // Round-robin scan starting at rr_q; first eligible requester wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand = (32'(rr_q) + k) % NumIn;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IdxWidth'(cand);
      end
    end
  end

  assign grant      = grant_valid & rst_ni;
  assign grant_read = grant & ~req_wen_i[grant_idx];

  assign bank_req_o   = grant;
  assign bank_we_o    = req_wen_i[grant_idx];
  assign bank_addr_o  = addr_arr[grant_idx];
  assign bank_be_o    = be_arr[grant_idx];
  assign bank_wdata_o = wdata_arr[grant_idx];

  // Response head: FIFO entry if any, otherwise the read arriving from the bank
  assign fifo_empty   = (cnt_q == '0);
  assign resp_valid_o = rst_ni & (~fifo_empty | inflight_q);
  assign resp_rdata_o = fifo_empty ? bank_rdata_i    : fifo_data_q[rptr_q];
  assign resp_idx_o   = fifo_empty ? inflight_idx_q  : fifo_idx_q[rptr_q];
  assign resp_meta_o  = fifo_empty ? inflight_meta_q : fifo_meta_q[rptr_q];

  assign pop       = resp_valid_o & resp_ready_i;
  assign fifo_pop  = pop & ~fifo_empty;
  // Arriving data bypasses storage only when it is consumed in the same cycle
  assign fifo_push = inflight_q & ~(fifo_empty & pop);

  // Next-state for pointer, occupancy and arbitration state
  always_comb begin
    rr_d       = rr_q;
    inflight_d = grant_read;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + OccWidth'(fifo_push) - OccWidth'(fifo_pop);
    if (grant) begin
      rr_d = (grant_idx == IdxWidth'(NumIn - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (fifo_push) begin
      wptr_d = (wptr_q == PtrWidth'(RespDepth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rptr_d = (rptr_q == PtrWidth'(RespDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Payload storage without reset; validity is tracked by the control state
  always_ff @(posedge clk_i) begin
    if (grant_read) begin
      inflight_idx_q  <= grant_idx;
      inflight_meta_q <= meta_arr[grant_idx];
    end
    if (fifo_push) begin
      fifo_data_q[wptr_q] <= bank_rdata_i;
      fifo_idx_q[wptr_q]  <= inflight_idx_q;
      fifo_meta_q[wptr_q] <= inflight_meta_q;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_push && !fifo_pop && cnt_q == OccWidth'(RespDepth)));
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occ_q <= (OccWidth+1)'(RespDepth));
`endif

endmodule

// File: tb/tb_tcdm_bank_scheduler.sv
// Bench for tcdm_bank_scheduler: directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_tcdm_bank_scheduler;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 8;
  localparam int RD = 2;
  localparam int BW = DW / 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, req_wen;
  logic [N*AW-1:0]   req_addr;
  logic [N*BW-1:0]   req_be;
  logic [N*DW-1:0]   req_wdata;
  logic [N*MW-1:0]   req_meta;
  logic              resp_valid, resp_ready;
  logic [IW-1:0]     resp_idx;
  logic [DW-1:0]     resp_rdata;
  logic [MW-1:0]     resp_meta;
  logic              bank_req, bank_we;
  logic [AW-1:0]     bank_addr;
  logic [BW-1:0]     bank_be;
  logic [DW-1:0]     bank_wdata;
  logic [DW-1:0]     bank_rdata;

  always #5 clk = ~clk;

  tcdm_bank_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .req_meta_i(req_meta),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_idx_o(resp_idx),
    .resp_rdata_o(resp_rdata), .resp_meta_o(resp_meta),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_be_o(bank_be), .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
  );

  // SRAM macro stand-in: one-cycle registered read, byte-enabled write
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (bank_req) begin
      if (bank_we) begin
        for (int b = 0; b < BW; b++)
          if (bank_be[b]) sram[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
      end else begin
        bank_rdata <= sram[bank_addr];
      end
    end
  end

  // Reference model: memory image, round-robin pointer, outstanding reads
  typedef struct {
    int            idx;
    logic [MW-1:0] meta;
    logic [DW-1:0] data;
  } exp_t;
  logic [DW-1:0] m_mem [256];
  int            m_rr;
  exp_t          m_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic wen, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wdata,
                         input logic [MW-1:0] meta);
    req_valid[i]          = 1'b1;
    req_wen[i]            = wen;
    req_addr[i*AW +: AW]  = addr;
    req_be[i*BW +: BW]    = be;
    req_wdata[i*DW +: DW] = wdata;
    req_meta[i*MW +: MW]  = meta;
  endtask

  // mode: 0 read, 1 write, 2 either
  task automatic new_req(input int i, input int mode);
    logic wen;
    wen = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
    set_req(i, wen, AW'($urandom_range(0, 15)), BW'($urandom_range(1, 15)),
            DW'($urandom), MW'($urandom));
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  task automatic step(output logic [N-1:0] acc);
    int g;
    int j;
    logic exp_rv;
    logic pop;
    logic [N-1:0] exp_ready;
    logic [AW-1:0] a;
    exp_t e;
    #1;
    acc = '0;
    if (!rst_n) begin
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_bank_req", bank_req, 0);
      check_eq("rst_resp_valid", resp_valid, 0);
      m_q.delete();
      m_rr = 0;
    end else begin
      exp_rv = (m_q.size() > 0);
      check_eq("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        check_eq("resp_idx", resp_idx, m_q[0].idx);
        check_eq("resp_meta", resp_meta, m_q[0].meta);
        check_eq("resp_rdata", resp_rdata, m_q[0].data);
      end
      pop = exp_rv && resp_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && req_valid[j] && (req_wen[j] || (m_q.size() - int'(pop) < RD))) g = j;
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      check_eq("req_ready", req_ready, exp_ready);
      check_eq("bank_req", bank_req, g >= 0);
      acc = req_ready;
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
        a = req_addr[g*AW +: AW];
        check_eq("bank_we", bank_we, req_wen[g]);
        check_eq("bank_addr", bank_addr, a);
        if (req_wen[g]) begin
          check_eq("bank_be", bank_be, req_be[g*BW +: BW]);
          check_eq("bank_wdata", bank_wdata, req_wdata[g*DW +: DW]);
          for (int b = 0; b < BW; b++)
            if (req_be[g*BW + b]) m_mem[a][8*b +: 8] = req_wdata[g*DW + 8*b +: 8];
          $display("txn wr req=%0d addr=%02h data=%08h", g, a, req_wdata[g*DW +: DW]);
        end else begin
          e.idx  = g;
          e.meta = req_meta[g*MW +: MW];
          e.data = m_mem[a];
          m_q.push_back(e);
          $display("txn rd req=%0d addr=%02h meta=%02h", g, a, e.meta);
        end
        m_rr = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  logic [N-1:0] acc;
  int gcount;
  logic [N-1:0] exp_seq;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]  = DW'($urandom);
      m_mem[i] = sram[i];
    end
    m_rr       = 0;
    rst_n      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_wen    = '0;
    req_addr   = '0;
    req_be     = '0;
    req_wdata  = '0;
    req_meta   = '0;

    // Reset with every requester valid
    for (int i = 0; i < N; i++) new_req(i, 0);
    @(negedge clk);
    step(acc);
    step(acc);
    rst_n = 1'b1;

    // Round-robin fairness with continuous reads and a ready consumer
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_seq = N'(1 << (c % N));
      check_eq("rr_seq", req_ready, exp_seq);
      step(acc);
      for (int i = 0; i < N; i++) if (acc[i]) new_req(i, 0);
    end
    req_valid = '0;
    repeat (3) step(acc);

    // Backpressure: only RD reads fit while the consumer stalls
    resp_ready = 1'b0;
    new_req(0, 0);
    new_req(1, 0);
    gcount = 0;
    repeat (5) begin
      step(acc);
      if (|acc) gcount++;
      for (int i = 0; i < 2; i++) if (acc[i]) new_req(i, 0);
    end
    check_eq("bp_grants", gcount, RD);
    resp_ready = 1'b1;
    #1;
    check_eq("bp_third", |req_ready, 1);
    step(acc);
    for (int i = 0; i < 2; i++) if (acc[i]) new_req(i, 0);
    resp_ready = 1'b0;

    // Credit bypass: a write wins past credit-blocked reads
    set_req(2, 1'b1, 8'h10, 4'hF, 32'h1234_5678, 8'h00);
    #1;
    check_eq("cb_ready", req_ready, 4'b0100);
    check_eq("cb_we", bank_we, 1);
    check_eq("cb_addr", bank_addr, 8'h10);
    step(acc);
    set_req(2, 1'b1, 8'h11, 4'hF, 32'h0000_0002, 8'h00);
    set_req(3, 1'b1, 8'h12, 4'hF, 32'h0000_0003, 8'h00);
    #1;
    check_eq("cb_rr3", req_ready, 4'b1000);
    step(acc);
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) step(acc);

    // Data and tag path: write then read back from another requester
    set_req(0, 1'b1, 8'h05, 4'hF, 32'hDEAD_BEEF, 8'h00);
    step(acc);
    req_valid = '0;
    set_req(3, 1'b0, 8'h05, 4'h0, 32'h0, 8'hA5);
    step(acc);
    req_valid = '0;
    check_eq("dt_valid", resp_valid, 1);
    check_eq("dt_rdata", resp_rdata, 32'hDEAD_BEEF);
    check_eq("dt_meta", resp_meta, 8'hA5);
    check_eq("dt_idx", resp_idx, 3);
    step(acc);

    // Reset one cycle after a read grant drops that read
    set_req(1, 1'b0, 8'h07, 4'h0, 32'h0, 8'h3C);
    step(acc);
    req_valid = '0;
    rst_n = 1'b0;
    step(acc);
    rst_n = 1'b1;
    repeat (3) begin
      #1;
      check_eq("mr_no_resp", resp_valid, 0);
      step(acc);
    end
    for (int i = 0; i < N; i++) new_req(i, 1);
    #1;
    check_eq("mr_rr0", req_ready, 4'b0001);
    step(acc);
    req_valid = '0;

    // Random traffic; valid/fields held until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          if ($urandom_range(0, 9) < 6) new_req(i, 2);
          else req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      step(acc);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) step(acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
